// File: rtl/xung_1hz_if.sv
// xung_1hz_if: divider outputs, the square wave q and its rising-edge strobe tick
interface xung_1hz_if;
  logic q;
  logic tick;
  modport master(output q, tick);
  modport slave(input q, tick);
endinterface

// File: rtl/xung_1hz.sv
// xung_1hz: free-running divider giving a 50% duty square wave at OUT_FREQ_HZ plus a rise strobe
// ports: clk system clock, rst sync active-high reset, o.q divided wave, o.tick one-cycle pulse as q rises
module xung_1hz #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OUT_FREQ_HZ = 1
) (
  input logic clk,
  input logic rst,
  xung_1hz_if.master o
);
  localparam int HALF = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);
  if (CLK_FREQ_HZ < 2 * OUT_FREQ_HZ) begin : g_bad
    $error("xung_1hz: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_q, q_d, tick_q, tick_d, wrap;
  always_comb begin
    wrap = cnt_q == LAST;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    q_d = wrap ? ~q_q : q_q;
    // strobe only on the 0->1 transition of q
    tick_d = wrap & ~q_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      q_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q <= q_d;
      tick_q <= tick_d;
    end
  end
  assign o.q = q_q;
  assign o.tick = tick_q;
endmodule

// File: tb/tb_xung_1hz.sv
// tb_xung_1hz: directed vectors against three divider configurations (HALF=5, HALF=1, truncated HALF=5)
module tb_xung_1hz;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  xung_1hz_if if5 ();
  xung_1hz_if if1 ();
  xung_1hz_if if11 ();
  xung_1hz #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) dut5 (.clk(clk), .rst(rst), .o(if5.master));
  xung_1hz #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut1 (.clk(clk), .rst(rst), .o(if1.master));
  xung_1hz #(.CLK_FREQ_HZ(11), .OUT_FREQ_HZ(1)) dut11 (.clk(clk), .rst(rst), .o(if11.master));
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [5:0] exp;
  } vec_t;
  vec_t tv [18];
  task automatic chk(input string n, input logic a, input logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %b want %b", n, a, e);
    end
  endtask
  task automatic step(input logic r);
    @(negedge clk) rst = r;
    @(posedge clk) #1;
  endtask
  initial begin
    int hi5, tk5, hi1, tk1, hi11, tk11;
    // exp = {q5, tick5, q1, tick1, q11, tick11} sampled just after each edge
    tv = '{
      '{1'b1, 6'b000000}, '{1'b1, 6'b000000}, '{1'b1, 6'b000000},
      '{1'b0, 6'b001100}, '{1'b0, 6'b000000}, '{1'b0, 6'b001100},
      '{1'b0, 6'b000000}, '{1'b0, 6'b111111}, '{1'b0, 6'b100010},
      '{1'b0, 6'b101110}, '{1'b0, 6'b100010}, '{1'b0, 6'b101110},
      '{1'b0, 6'b000000}, '{1'b0, 6'b001100}, '{1'b0, 6'b000000},
      '{1'b0, 6'b001100}, '{1'b0, 6'b000000}, '{1'b0, 6'b111111}
    };
    for (int i = 0; i < 18; i++) begin
      step(tv[i].rst);
      chk($sformatf("v%0d q5", i), if5.q, tv[i].exp[5]);
      chk($sformatf("v%0d tick5", i), if5.tick, tv[i].exp[4]);
      chk($sformatf("v%0d q1", i), if1.q, tv[i].exp[3]);
      chk($sformatf("v%0d tick1", i), if1.tick, tv[i].exp[2]);
      chk($sformatf("v%0d q11", i), if11.q, tv[i].exp[1]);
      chk($sformatf("v%0d tick11", i), if11.tick, tv[i].exp[0]);
    end
    // q5 rose at the last vector; three more edges leave q=1 with cnt=3
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("mid q5 high", if5.q, 1'b1);
      chk("mid tick5 low", if5.tick, 1'b0);
    end
    step(1'b1);
    chk("mid rst q5", if5.q, 1'b0);
    chk("mid rst tick5", if5.tick, 1'b0);
    chk("mid rst q1", if1.q, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      chk($sformatf("rerun e%0d q5", i), if5.q, i >= 4);
      chk($sformatf("rerun e%0d tick5", i), if5.tick, i == 4);
      chk($sformatf("rerun e%0d q11", i), if11.q, i >= 4);
    end
    // fresh reset, then 40 edges: duty and strobe counts
    step(1'b1);
    hi5 = 0; tk5 = 0; hi1 = 0; tk1 = 0; hi11 = 0; tk11 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      hi5 += int'(if5.q); tk5 += int'(if5.tick);
      hi1 += int'(if1.q); tk1 += int'(if1.tick);
      hi11 += int'(if11.q); tk11 += int'(if11.tick);
      if (if5.tick && !if5.q) chk("tick5 without q", if5.tick, 1'b0);
      if (if1.tick !== if1.q) chk("tick1 aligned q1", if1.tick, if1.q);
    end
    chk("duty5", hi5 == 20, 1'b1);
    chk("ticks5", tk5 == 4, 1'b1);
    chk("duty1", hi1 == 20, 1'b1);
    chk("ticks1", tk1 == 20, 1'b1);
    chk("duty11", hi11 == 20, 1'b1);
    chk("ticks11", tk11 == 4, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
